// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state encoding and the default datapath width.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Handshake/data bundle between the ALU control FSM (master) and the
// bit-serial subtractor (slave). Flag outputs exist only when
// SERIAL_SUB_FLAGS_EN is defined.
interface serial_subtractor_if
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;
`ifdef SERIAL_SUB_FLAGS_EN
    logic             z;
    logic             n;
    logic             v;
`endif

`ifdef SERIAL_SUB_FLAGS_EN
    modport master (output start, a, b, input busy, done, d, bout, z, n, v);
    modport slave  (input start, a, b, output busy, done, d, bout, z, n, v);
`else
    modport master (output start, a, b, input busy, done, d, bout);
    modport slave  (input start, a, b, output busy, done, d, bout);
`endif

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, d = a - b, one bit per clock LSB first
// through a single full_subtractor cell and a registered borrow.
// Optional feature macro: SERIAL_SUB_FLAGS_EN adds z/n/v result flags.
module serial_subtractor
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
)
(
    input logic                clk,
    input logic                rst,
    serial_subtractor_if.slave bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
`ifdef SERIAL_SUB_FLAGS_EN
    logic             z_q, z_d;
    logic             n_q, n_d;
    logic             v_q, v_d;
`endif

    logic             cell_diff;
    logic             cell_borrow;
    logic [WIDTH-1:0] res_next;

    full_subtractor u_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (borrow_q),
        .d    (cell_diff),
        .bout (cell_borrow)
    );

    // Next-state and datapath: accept in IDLE, crunch one bit per RUN cycle,
    // publish the full word only on the final bit so d never shows partials.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        d_d      = d_q;
        bout_d   = bout_q;
`ifdef SERIAL_SUB_FLAGS_EN
        z_d      = z_q;
        n_d      = n_q;
        v_d      = v_q;
`endif
        res_next = {cell_diff, res_q[WIDTH-1:1]};

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sh_d   = bus.a;
                    b_sh_d   = bus.b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_d    = res_next;
                borrow_d = cell_borrow;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    d_d     = res_next;
                    bout_d  = cell_borrow;
                    state_d = DONE;
`ifdef SERIAL_SUB_FLAGS_EN
                    // On the last bit the shift-register LSBs are the latched operand MSBs.
                    z_d = (res_next == '0);
                    n_d = cell_diff;
                    v_d = (a_sh_q[0] ^ b_sh_q[0]) & (cell_diff ^ a_sh_q[0]);
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset that aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            d_q      <= '0;
            bout_q   <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            d_q      <= d_d;
            bout_q   <= bout_d;
`ifdef SERIAL_SUB_FLAGS_EN
            z_q      <= z_d;
            n_q      <= n_d;
            v_q      <= v_d;
`endif
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.d    = d_q;
    assign bus.bout = bout_q;
`ifdef SERIAL_SUB_FLAGS_EN
    assign bus.z    = z_q;
    assign bus.n    = n_q;
    assign bus.v    = v_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=8.
// Flag checks are compiled in when SERIAL_SUB_FLAGS_EN is defined.
module tb_serial_subtractor;

    logic clk;
    logic rst;
    int   n_compared;
    int   n_mismatched;

    serial_subtractor_if #(.WIDTH(8)) bus ();

    serial_subtractor #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running 10 ns clock; rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts one operation and follows it to its done pulse, measuring timing.
    // Returns at the negedge where done is seen (latency 0 means it never came).
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                          output int busy_cycles, output int latency, output bit d_held);
        logic [7:0] prev_d;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        prev_d    = bus.d;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~av;
        bus.b     = ~bv;
        busy_cycles = 0;
        latency     = 0;
        d_held      = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            if (i > 1) @(negedge clk);
            if (bus.busy) begin
                busy_cycles++;
                if (bus.d !== prev_d) d_held = 1'b0;
            end
            if (bus.done) begin
                latency = i;
                break;
            end
        end
    endtask

    // Reset state of every output.
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_compared += 4;
        if (bus.busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        if (bus.done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
        if (bus.d !== 8'h00)   begin n_mismatched++; $display("[TB] FAIL reset_d: got %h expected 00", bus.d); end
        if (bus.bout !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_bout: got %b expected 0", bus.bout); end
`ifdef SERIAL_SUB_FLAGS_EN
        n_compared += 3;
        if (bus.z !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_z: got %b expected 0", bus.z); end
        if (bus.n !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_n: got %b expected 0", bus.n); end
        if (bus.v !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_v: got %b expected 0", bus.v); end
`endif
        rst = 1'b0;
    endtask

    // 0x5A - 0x3C = 0x1E: latency, busy width, no partial results, one-cycle done.
    task automatic test_basic();
        int busy_cycles, latency;
        bit d_held;
        run_op(8'h5A, 8'h3C, busy_cycles, latency, d_held);
        n_compared += 5;
        if (latency !== 9)     begin n_mismatched++; $display("[TB] FAIL basic_latency: got %0d expected 9", latency); end
        if (busy_cycles !== 8) begin n_mismatched++; $display("[TB] FAIL basic_busy_cycles: got %0d expected 8", busy_cycles); end
        if (d_held !== 1'b1)   begin n_mismatched++; $display("[TB] FAIL basic_d_held: got %b expected 1", d_held); end
        if (bus.d !== 8'h1E)   begin n_mismatched++; $display("[TB] FAIL basic_d: got %h expected 1e", bus.d); end
        if (bus.bout !== 1'b0) begin n_mismatched++; $display("[TB] FAIL basic_bout: got %b expected 0", bus.bout); end
        @(negedge clk);
        n_compared += 3;
        if (bus.done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL basic_done_pulse: got %b expected 0", bus.done); end
        if (bus.busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL basic_busy_after: got %b expected 0", bus.busy); end
        if (bus.d !== 8'h1E)   begin n_mismatched++; $display("[TB] FAIL basic_d_hold: got %h expected 1e", bus.d); end
    endtask

    // 0x00 - 0x01 wraps to 0xFF with borrow out.
    task automatic test_wrap();
        int busy_cycles, latency;
        bit d_held;
        run_op(8'h00, 8'h01, busy_cycles, latency, d_held);
        n_compared += 3;
        if (latency !== 9)     begin n_mismatched++; $display("[TB] FAIL wrap_latency: got %0d expected 9", latency); end
        if (bus.d !== 8'hFF)   begin n_mismatched++; $display("[TB] FAIL wrap_d: got %h expected ff", bus.d); end
        if (bus.bout !== 1'b1) begin n_mismatched++; $display("[TB] FAIL wrap_bout: got %b expected 1", bus.bout); end
`ifdef SERIAL_SUB_FLAGS_EN
        n_compared += 3;
        if (bus.n !== 1'b1) begin n_mismatched++; $display("[TB] FAIL wrap_n: got %b expected 1", bus.n); end
        if (bus.z !== 1'b0) begin n_mismatched++; $display("[TB] FAIL wrap_z: got %b expected 0", bus.z); end
        if (bus.v !== 1'b0) begin n_mismatched++; $display("[TB] FAIL wrap_v: got %b expected 0", bus.v); end
`endif
    endtask

    // Signed overflow case 0x80 - 0x01, then equal operands giving zero.
    task automatic test_overflow_zero();
        int busy_cycles, latency;
        bit d_held;
        run_op(8'h80, 8'h01, busy_cycles, latency, d_held);
        n_compared += 2;
        if (bus.d !== 8'h7F)   begin n_mismatched++; $display("[TB] FAIL ovf_d: got %h expected 7f", bus.d); end
        if (bus.bout !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ovf_bout: got %b expected 0", bus.bout); end
`ifdef SERIAL_SUB_FLAGS_EN
        n_compared += 3;
        if (bus.v !== 1'b1) begin n_mismatched++; $display("[TB] FAIL ovf_v: got %b expected 1", bus.v); end
        if (bus.n !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ovf_n: got %b expected 0", bus.n); end
        if (bus.z !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ovf_z: got %b expected 0", bus.z); end
`endif
        run_op(8'h33, 8'h33, busy_cycles, latency, d_held);
        n_compared += 2;
        if (bus.d !== 8'h00)   begin n_mismatched++; $display("[TB] FAIL zero_d: got %h expected 00", bus.d); end
        if (bus.bout !== 1'b0) begin n_mismatched++; $display("[TB] FAIL zero_bout: got %b expected 0", bus.bout); end
`ifdef SERIAL_SUB_FLAGS_EN
        n_compared += 2;
        if (bus.z !== 1'b1) begin n_mismatched++; $display("[TB] FAIL zero_z: got %b expected 1", bus.z); end
        if (bus.v !== 1'b0) begin n_mismatched++; $display("[TB] FAIL zero_v: got %b expected 0", bus.v); end
`endif
    endtask

    // start pulses during RUN (cycle 3) and during DONE must both be ignored.
    task automatic test_ignored_start();
        int done_count;
        int done_at;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h10;
        bus.b     = 8'h01;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 8'hFF;
        bus.b     = 8'h00;
        done_count = 0;
        done_at    = 0;
        for (int i = 1; i <= 20; i++) begin
            if (i > 1) @(negedge clk);
            if (bus.done) begin
                done_count++;
                done_at = i;
            end
            bus.start = (i == 3) || bus.done;
        end
        bus.start = 1'b0;
        n_compared += 5;
        if (done_count !== 1)  begin n_mismatched++; $display("[TB] FAIL ignore_done_count: got %0d expected 1", done_count); end
        if (done_at !== 9)     begin n_mismatched++; $display("[TB] FAIL ignore_done_at: got %0d expected 9", done_at); end
        if (bus.d !== 8'h0F)   begin n_mismatched++; $display("[TB] FAIL ignore_d: got %h expected 0f", bus.d); end
        if (bus.bout !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ignore_bout: got %b expected 0", bus.bout); end
        if (bus.busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ignore_busy_end: got %b expected 0", bus.busy); end
    endtask

    // Reset at RUN cycle 4 (with start also high) aborts; a fresh start then completes.
    task automatic test_reset_abort();
        int done_count;
        int busy_cycles, latency;
        bit d_held;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h80;
        bus.b     = 8'h01;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst       = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        n_compared += 4;
        if (bus.busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL abort_busy: got %b expected 0", bus.busy); end
        if (bus.done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL abort_done: got %b expected 0", bus.done); end
        if (bus.d !== 8'h00)   begin n_mismatched++; $display("[TB] FAIL abort_d: got %h expected 00", bus.d); end
        if (bus.bout !== 1'b0) begin n_mismatched++; $display("[TB] FAIL abort_bout: got %b expected 0", bus.bout); end
        done_count = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_count++;
        end
        n_compared += 1;
        if (done_count !== 0) begin n_mismatched++; $display("[TB] FAIL abort_quiet: got %0d active cycles expected 0", done_count); end
        run_op(8'h5A, 8'h3C, busy_cycles, latency, d_held);
        n_compared += 3;
        if (latency !== 9)     begin n_mismatched++; $display("[TB] FAIL abort_restart_latency: got %0d expected 9", latency); end
        if (busy_cycles !== 8) begin n_mismatched++; $display("[TB] FAIL abort_restart_busy: got %0d expected 8", busy_cycles); end
        if (bus.d !== 8'h1E)   begin n_mismatched++; $display("[TB] FAIL abort_restart_d: got %h expected 1e", bus.d); end
    endtask

    // start held high: one accept every 10 cycles, done never on consecutive cycles.
    task automatic test_back_to_back();
        int  done_count;
        int  last_done;
        bit  prev_done;
        bit  idle_seen;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h09;
        bus.b     = 8'h04;
        done_count = 0;
        last_done  = 0;
        prev_done  = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.done) begin
                done_count++;
                n_compared += 2;
                if (bus.d !== 8'h05) begin n_mismatched++; $display("[TB] FAIL b2b_d: got %h expected 05", bus.d); end
                if (prev_done) begin n_mismatched++; $display("[TB] FAIL b2b_consecutive_done: got 1 expected 0 at cycle %0d", i); end
                if (last_done != 0) begin
                    n_compared += 1;
                    if (i - last_done !== 10) begin n_mismatched++; $display("[TB] FAIL b2b_interval: got %0d expected 10", i - last_done); end
                end
                last_done = i;
            end
            prev_done = bus.done;
        end
        bus.start = 1'b0;
        n_compared += 1;
        if (done_count !== 4) begin n_mismatched++; $display("[TB] FAIL b2b_done_count: got %0d expected 4", done_count); end
        idle_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!bus.busy && !bus.done) begin
                idle_seen = 1'b1;
                break;
            end
        end
        n_compared += 1;
        if (idle_seen !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_drain: got %b expected 1", idle_seen); end
    endtask

    // Test sequence and summary.
    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        $display("[TB] starting serial_subtractor bench");
        test_reset();
        test_basic();
        test_wrap();
        test_overflow_zero();
        test_ignored_start();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
